fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch.sv | 100 ++++++++++
 tb/tb_fetch.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared core definitions for the fetch stage: state encoding, pc geometry
// and the next-pc legality check reused by later fetch variants.
package fetch_pkg;

    localparam int PC_W    = 27;
    localparam int ALIGN_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_VALID,
        ST_FAULT
    } state_e;

    // A next pc is legal when word aligned and inside the 2^aw-word memory.
    function automatic logic npc_legal(input logic [PC_W-1:0] npc, input int aw);
        logic [PC_W-1:0] hi_mask;
        hi_mask = '1 << (aw + ALIGN_W);
        return (npc[ALIGN_W-1:0] == '0) && ((npc & hi_mask) == '0);
    endfunction

endpackage

// File: rtl/fetch.sv
// Single-issue instruction fetch: one memory read per instruction, holds the
// instruction until decode accepts it, and locks up on an illegal next pc.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [26:0] RESET_PC = 27'h0000000,
    parameter int          IMEM_AW  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        inst,
    output logic [26:0]        pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    input  logic [26:0]        npc,
    output logic               fault,
    output logic [31:0]        retired
);

    state_e      state_q, state_d;
    logic [26:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] retired_q, retired_d;
    logic        fault_q, fault_d;

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                inst_d  = imem_rdata;
                state_d = ST_VALID;
            end
            ST_VALID: begin
                if (inst_ready) begin
                    if (npc_legal(npc, IMEM_AW)) begin
                        pc_d      = npc;
                        retired_d = retired_q + 32'd1;
                        state_d   = ST_REQ;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

    // A read still in flight at reset is dropped: IDLE never samples imem_rdata.
    assign imem_en    = (state_q == ST_REQ);
    assign inst_valid = (state_q == ST_VALID);
    assign imem_addr  = pc_q[IMEM_AW+1:2];
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign fault      = fault_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: registered memory model, expected
// (pc, inst) pairs queued on each fetch request and popped on each accept.
module tb_fetch;

    localparam logic [26:0] RESET_PC = 27'h0000000;
    localparam int          IMEM_AW  = 15;

    typedef struct packed {
        logic [26:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        inst;
    logic [26:0]        pc;
    logic               inst_valid;
    logic               inst_ready;
    logic [26:0]        npc;
    logic               fault;
    logic [31:0]        retired;

    logic [31:0] mem [0:(1<<IMEM_AW)-1];
    exp_t        exp_q[$];
    int          total_cnt = 0;
    int          pass_cnt  = 0;

    fetch #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .pc         (pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .npc        (npc),
        .fault      (fault),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after imem_en.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    function automatic exp_t model_fetch(input logic [26:0] a);
        logic [IMEM_AW-1:0] w;
        exp_t e;
        w      = a[IMEM_AW+1:2];
        e.pc   = a;
        e.inst = mem[w];
        return e;
    endfunction

    // Scoreboard: every accepted instruction must match the oldest queued fetch.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && inst_valid && inst_ready) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty: got pc=%h inst=%h, expected a queued fetch", pc, inst);
            end else begin
                e = exp_q.pop_front();
                if (pc !== e.pc || inst !== e.inst)
                    $display("FAIL scoreboard: got pc=%h inst=%h, expected pc=%h inst=%h",
                             pc, inst, e.pc, e.inst);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        start      = 1'b0;
        inst_ready = 1'b0;
        npc        = '0;
        exp_q.delete();
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        exp_q.push_back(model_fetch(RESET_PC));
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int exp_n, input string name);
        int n;
        n = 0;
        while (!inst_valid && n < 20) begin
            step();
            n++;
        end
        total_cnt++;
        if (!inst_valid || n != exp_n)
            $display("FAIL %s_latency: got %0d cycles (valid=%b), expected %0d", name, n, inst_valid, exp_n);
        else
            pass_cnt++;
    endtask

    task automatic accept(input logic [26:0] next, input bit legal);
        npc        = next;
        inst_ready = 1'b1;
        if (legal) exp_q.push_back(model_fetch(next));
        step();
        inst_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        start      = 1'b0;
        inst_ready = 1'b1;
        npc        = '0;
        repeat (3) step();
        total_cnt++;
        if ({pc, inst, inst_valid, imem_en, fault, retired} !== {RESET_PC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0})
            $display("FAIL reset_values: got pc=%h inst=%h v=%b en=%b f=%b r=%h, expected all zero",
                     pc, inst, inst_valid, imem_en, fault, retired);
        else
            pass_cnt++;
        rst        = 1'b1;
        inst_ready = 1'b0;
        repeat (3) step();
        total_cnt++;
        if (imem_en !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL idle_wait: got en=%b v=%b, expected 0 0", imem_en, inst_valid);
        else
            pass_cnt++;
    endtask

    task automatic test_basic();
        do_start();
        total_cnt++;
        if (imem_en !== 1'b1 || imem_addr !== '0)
            $display("FAIL first_req: got en=%b addr=%h, expected 1 0", imem_en, imem_addr);
        else
            pass_cnt++;
        wait_valid(2, "first");
        accept(27'h4, 1'b1);
        wait_valid(2, "second");
        accept(27'h8, 1'b1);
        total_cnt++;
        if (retired !== 32'd2)
            $display("FAIL retired_two: got %0d, expected 2", retired);
        else
            pass_cnt++;
    endtask

    task automatic test_stall();
        exp_t e;
        e = model_fetch(27'h8);
        wait_valid(2, "third");
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({pc, inst, inst_valid, imem_en, retired} !== {e.pc, e.inst, 1'b1, 1'b0, 32'd2})
                $display("FAIL stall_hold: cycle %0d got pc=%h inst=%h v=%b en=%b r=%0d, expected pc=%h inst=%h 1 0 2",
                         i, pc, inst, inst_valid, imem_en, retired, e.pc, e.inst);
            else
                pass_cnt++;
            step();
        end
        accept(27'h8, 1'b1);
        wait_valid(2, "self_loop");
        accept(27'h001FFFC, 1'b1);
        total_cnt++;
        if (imem_en !== 1'b1 || imem_addr !== 15'h7FFF)
            $display("FAIL top_word: got en=%b addr=%h, expected 1 7fff", imem_en, imem_addr);
        else
            pass_cnt++;
        wait_valid(2, "top_word");
        accept(27'h0020000, 1'b0);
        total_cnt++;
        if ({fault, inst_valid, pc, retired} !== {1'b1, 1'b0, 27'h001FFFC, 32'd4})
            $display("FAIL range_fault: got f=%b v=%b pc=%h r=%0d, expected 1 0 001fffc 4",
                     fault, inst_valid, pc, retired);
        else
            pass_cnt++;
    endtask

    task automatic test_misaligned();
        do_reset();
        do_start();
        wait_valid(2, "misaligned");
        accept(27'h0000006, 1'b0);
        total_cnt++;
        if ({fault, inst_valid, imem_en, pc, retired} !== {1'b1, 1'b0, 1'b0, 27'h0, 32'd0})
            $display("FAIL align_fault: got f=%b v=%b en=%b pc=%h r=%0d, expected 1 0 0 0 0",
                     fault, inst_valid, imem_en, pc, retired);
        else
            pass_cnt++;
        start      = 1'b1;
        inst_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        inst_ready = 1'b0;
        total_cnt++;
        if ({fault, inst_valid, imem_en, pc, retired} !== {1'b1, 1'b0, 1'b0, 27'h0, 32'd0})
            $display("FAIL fault_sticky: got f=%b v=%b en=%b pc=%h r=%0d, expected 1 0 0 0 0",
                     fault, inst_valid, imem_en, pc, retired);
        else
            pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_start();
        step();
        rst = 1'b0;
        #1;
        exp_q.delete();
        total_cnt++;
        if ({pc, inst, inst_valid, imem_en, fault, retired} !== {RESET_PC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0})
            $display("FAIL mid_reset: got pc=%h inst=%h v=%b en=%b f=%b r=%h, expected all zero",
                     pc, inst, inst_valid, imem_en, fault, retired);
        else
            pass_cnt++;
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++;
            if (imem_en !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0)
                $display("FAIL post_reset_idle: cycle %0d got en=%b v=%b inst=%h, expected 0 0 0",
                         i, imem_en, inst_valid, inst);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        do_start();
        wait_valid(2, "wrap");
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        accept(27'h4, 1'b1);
        total_cnt++;
        if (retired !== 32'h0 || fault !== 1'b0 || imem_en !== 1'b1)
            $display("FAIL retired_wrap: got r=%h f=%b en=%b, expected 0 0 1", retired, fault, imem_en);
        else
            pass_cnt++;
        wait_valid(2, "after_wrap");
        accept(27'h8, 1'b1);
        total_cnt++;
        if (retired !== 32'd1)
            $display("FAIL retired_after_wrap: got %0d, expected 1", retired);
        else
            pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = 32'hC0DE0000 ^ i;
        mem[0]      = 32'h11111111;
        mem[1]      = 32'h22222222;
        mem[2]      = 32'h33333333;
        mem[15'h7FFF] = 32'hDEADBEEF;
        imem_rdata  = '0;

        test_reset();
        test_basic();
        test_stall();
        test_misaligned();
        test_reset_mid();
        test_wrap();
        do_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
